// File: rtl/div_pkg.sv
// div_pkg
// Shared definitions for the iterative restoring divider.
//   div_state_t    : controller states (IDLE/BUSY/FIXUP/DONE)
//   DIV_WIDTH      : default operand width
//   CNT_W          : iteration counter width for the default operand width
//   MAX_W          : widest operand the helper functions can handle
//   cond_negate    : two's-complement negate when 'neg' is set
//   twos_magnitude : magnitude of a w-bit value, sign taken only in signed mode
package div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } div_state_t;

  localparam int DIV_WIDTH = 64;
  localparam int CNT_W     = $clog2(DIV_WIDTH);
  localparam int MAX_W     = 128;

  // Operands are zero-extended to MAX_W before calling; the low w bits of the
  // result are the w-bit two's-complement answer.
  function automatic logic [MAX_W-1:0] cond_negate(input logic [MAX_W-1:0] x,
                                                   input logic neg);
    return neg ? -x : x;
  endfunction

  // The most-negative value comes back as its unsigned magnitude (1 << (w-1)),
  // which fits in w bits without overflow.
  function automatic logic [MAX_W-1:0] twos_magnitude(input logic [MAX_W-1:0] x,
                                                      input int unsigned w,
                                                      input logic is_signed);
    return cond_negate(x, is_signed & x[w-1]);
  endfunction

endpackage

// File: rtl/div_step.sv
// div_step
// One combinational radix-2 restoring division step.
// Ports:
//   rem_in      : partial remainder (WIDTH+1 bits)
//   quo_in      : quotient / remaining dividend bits
//   divisor_mag : divisor magnitude
//   rem_out     : next partial remainder
//   quo_out     : next quotient, new bit shifted in at the LSB
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor_mag,
  output logic [WIDTH:0]   rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;
  logic             borrow;

  // The remainder always stays below the divisor, so the shifted value is
  // below 2^(WIDTH+1) and the top bit of the difference is a clean borrow.
  always_comb begin
    shifted = {rem_in, quo_in[WIDTH-1]};
    diff    = shifted - {2'b00, divisor_mag};
    borrow  = diff[WIDTH+1];
    rem_out = borrow ? shifted[WIDTH:0] : diff[WIDTH:0];
    quo_out = {quo_in[WIDTH-2:0], ~borrow};
  end

endmodule

// File: rtl/iter_divider.sv
// iter_divider
// Multi-cycle radix-2 restoring divider with RISC-V DIV/DIVU/REM/REMU results,
// including the divide-by-zero and signed-overflow cases.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid/in_ready     : operand handshake (ready only while idle)
//   in_signed             : 1 = signed, 0 = unsigned
//   dividend, divisor     : operands
//   flush                 : abandon any operation or pending result
//   out_valid/out_ready   : result handshake
//   quotient, remainder   : registered results, stable while out_valid
// Build option:
//   DIVIDER_EARLY_TERM_EN : resolve divide-by-zero, signed overflow and
//                           unsigned dividend < divisor at accept time.
//   WIDTH may be at most div_pkg::MAX_W.
module iter_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH);

  div_state_t state, state_next;

  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] div_mag;
  logic [WIDTH-1:0] dividend_q;
  logic             sign_q, sign_r;
  logic             div_zero, sig_ovf;

  logic [WIDTH:0]   rem_step;
  logic [WIDTH-1:0] quo_step;

  logic             accept;
  logic             acc_sa, acc_sb;
  logic             acc_zero, acc_ovf;
  logic             early_hit;
  logic [WIDTH-1:0] early_q, early_r;
  logic [WIDTH-1:0] fix_q, fix_r;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in      (rem),
    .quo_in      (quo),
    .divisor_mag (div_mag),
    .rem_out     (rem_step),
    .quo_out     (quo_step)
  );

  // Operand classification at accept time; flush blocks a same-cycle accept.
  always_comb begin
    accept   = in_valid && (state == IDLE) && !flush;
    acc_sa   = in_signed & dividend[WIDTH-1];
    acc_sb   = in_signed & divisor[WIDTH-1];
    acc_zero = (divisor == '0);
    acc_ovf  = in_signed && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
  end

`ifdef DIVIDER_EARLY_TERM_EN
  // Cases whose answer is known without iterating go straight to DONE.
  always_comb begin
    early_hit = acc_zero | acc_ovf | (~in_signed & (dividend < divisor));
    early_q   = '0;
    early_r   = dividend;
    if (acc_zero) begin
      early_q = '1;
      early_r = dividend;
    end else if (acc_ovf) begin
      early_q = dividend;
      early_r = '0;
    end
  end
`else
  always_comb begin
    early_hit = 1'b0;
    early_q   = '0;
    early_r   = '0;
  end
`endif

  // Sign correction followed by the architectural override results.
  always_comb begin
    fix_q = WIDTH'(cond_negate(MAX_W'(quo), sign_q));
    fix_r = WIDTH'(cond_negate(MAX_W'(rem[WIDTH-1:0]), sign_r));
    if (div_zero) begin
      fix_q = '1;
      fix_r = dividend_q;
    end else if (sig_ovf) begin
      fix_q = dividend_q;
      fix_r = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Flush overrides every other transition, including a pending handoff.
  always_comb begin
    state_next = state;
    in_ready   = (state == IDLE);
    out_valid  = (state == DONE);
    unique case (state)
      IDLE:    if (accept) state_next = early_hit ? DONE : BUSY;
      BUSY:    if (cnt == '0) state_next = FIXUP;
      FIXUP:   state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  // Datapath: operand latch, one step per BUSY cycle, result capture in FIXUP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      rem        <= '0;
      quo        <= '0;
      div_mag    <= '0;
      dividend_q <= '0;
      sign_q     <= 1'b0;
      sign_r     <= 1'b0;
      div_zero   <= 1'b0;
      sig_ovf    <= 1'b0;
      quotient   <= '0;
      remainder  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            dividend_q <= dividend;
            div_zero   <= acc_zero;
            sig_ovf    <= acc_ovf;
            sign_q     <= acc_sa ^ acc_sb;
            sign_r     <= acc_sa;
            quo        <= WIDTH'(twos_magnitude(MAX_W'(dividend), WIDTH, in_signed));
            div_mag    <= WIDTH'(twos_magnitude(MAX_W'(divisor), WIDTH, in_signed));
            rem        <= '0;
            cnt        <= CW'(WIDTH - 1);
            if (early_hit) begin
              quotient  <= early_q;
              remainder <= early_r;
            end
          end
        end
        BUSY: begin
          rem <= rem_step;
          quo <= quo_step;
          if (cnt != '0) cnt <= cnt - CW'(1);
        end
        FIXUP: begin
          quotient  <= fix_q;
          remainder <= fix_r;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// tb_iter_divider
// Directed table of operand pairs with hand-computed RISC-V results and
// latencies, plus sequences for backpressure, flush and mid-operation reset.
module tb_iter_divider;

  localparam int W = 64;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         in_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  int checks = 0;
  int errors = 0;

  iter_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_signed (in_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         sgn;
    logic         early;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  task automatic checkOutput(input string name, input logic [W-1:0] actual,
                             input logic [W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // Presents one operand pair and returns at the first negedge after accept.
  task automatic startOp(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    int guard;
    @(negedge clk);
    in_signed = sgn;
    dividend  = a;
    divisor   = b;
    in_valid  = 1'b1;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("[TB] FAIL accept_wait actual=in_ready_low required=in_ready_high");
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // lat counts negedges after the accept edge until out_valid is seen.
  task automatic waitResult(output logic [W-1:0] q, output logic [W-1:0] r, output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    q = quotient;
    r = remainder;
  endtask

  task automatic applyStimulus(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                               output logic [W-1:0] q, output logic [W-1:0] r,
                               output int lat);
    startOp(sgn, a, b);
    waitResult(q, r, lat);
  endtask

  function automatic int expLatency(input logic early);
`ifdef DIVIDER_EARLY_TERM_EN
    return early ? 1 : W + 2;
`else
    return (early === 1'bx) ? 0 : W + 2;
`endif
  endfunction

  initial begin
    logic [W-1:0] q, r, q_hold, r_hold;
    int           lat;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    flush     = 1'b0;
    out_ready = 1'b1;

    vecs[0]  = '{1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2};
    vecs[1]  = '{1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
                 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[2]  = '{1'b1, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE,
                 64'hFFFF_FFFF_FFFF_FFFD, 64'd1};
    vecs[3]  = '{1'b1, 1'b1, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5};
    vecs[4]  = '{1'b0, 1'b1, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5};
    vecs[5]  = '{1'b1, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                 64'h8000_0000_0000_0000, 64'd0};
    vecs[6]  = '{1'b0, 1'b0, 64'd9, 64'd3, 64'd3, 64'd0};
    vecs[7]  = '{1'b0, 1'b1, 64'd3, 64'd10, 64'd0, 64'd3};
    vecs[8]  = '{1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9,
                 64'd14, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[9]  = '{1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
                 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
    vecs[10] = '{1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10,
                 64'h0FFF_FFFF_FFFF_FFFF, 64'hF};
    vecs[11] = '{1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,
                 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[12] = '{1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                 64'd0, 64'h8000_0000_0000_0000};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", W'(in_ready), W'(1));
    checkOutput("rst_out_valid", W'(out_valid), W'(0));
    checkOutput("rst_quotient", quotient, '0);
    checkOutput("rst_remainder", remainder, '0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i].sgn, vecs[i].a, vecs[i].b, q, r, lat);
      checkOutput($sformatf("v%0d_quotient", i), q, vecs[i].q);
      checkOutput($sformatf("v%0d_remainder", i), r, vecs[i].r);
      checkOutput($sformatf("v%0d_latency", i), W'(lat), W'(expLatency(vecs[i].early)));
    end

    // Backpressure: hold the result for 5 DONE cycles, hand off on the 6th
    @(negedge clk);
    out_ready = 1'b0;
    applyStimulus(1'b0, 64'd1000, 64'd3, q, r, lat);
    checkOutput("bp_quotient", q, 64'd333);
    checkOutput("bp_remainder", r, 64'd1);
    q_hold = q;
    r_hold = r;
    for (int c = 0; c < 5; c++) begin
      checkOutput($sformatf("bp_c%0d_out_valid", c + 1), W'(out_valid), W'(1));
      checkOutput($sformatf("bp_c%0d_in_ready", c + 1), W'(in_ready), W'(0));
      checkOutput($sformatf("bp_c%0d_quotient", c + 1), quotient, q_hold);
      checkOutput($sformatf("bp_c%0d_remainder", c + 1), remainder, r_hold);
      @(negedge clk);
    end
    checkOutput("bp_c6_out_valid", W'(out_valid), W'(1));
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_after_in_ready", W'(in_ready), W'(1));
    checkOutput("bp_after_out_valid", W'(out_valid), W'(0));

    // Flush at BUSY cycle 10, then a clean 9/3
    startOp(1'b0, 64'hFFFF_0000_1234_5678, 64'd13);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_busy_in_ready", W'(in_ready), W'(1));
    checkOutput("flush_busy_out_valid", W'(out_valid), W'(0));
    applyStimulus(1'b0, 64'd9, 64'd3, q, r, lat);
    checkOutput("flush_next_quotient", q, 64'd3);
    checkOutput("flush_next_remainder", r, 64'd0);
    checkOutput("flush_next_latency", W'(lat), W'(W + 2));

    // Flush while a result is held in DONE
    @(negedge clk);
    out_ready = 1'b0;
    applyStimulus(1'b0, 64'd20, 64'd6, q, r, lat);
    checkOutput("flush_done_quotient", q, 64'd3);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    out_ready = 1'b1;
    checkOutput("flush_done_out_valid", W'(out_valid), W'(0));
    checkOutput("flush_done_in_ready", W'(in_ready), W'(1));

    // Asynchronous reset at BUSY cycle 20, then a clean 9/3
    startOp(1'b1, 64'hFFFF_FFFF_FFFF_0000, 64'd7);
    repeat (19) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_busy_quotient", quotient, '0);
    checkOutput("rst_busy_remainder", remainder, '0);
    checkOutput("rst_busy_in_ready", W'(in_ready), W'(1));
    checkOutput("rst_busy_out_valid", W'(out_valid), W'(0));
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 64'd9, 64'd3, q, r, lat);
    checkOutput("rst_next_quotient", q, 64'd3);
    checkOutput("rst_next_remainder", r, 64'd0);
    checkOutput("rst_next_latency", W'(lat), W'(W + 2));

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iter_divider.md
# iter_divider

Multi-cycle radix-2 restoring integer divider for the CPU execute stage, the sequential counterpart to the single-cycle prefix adder. It accepts a dividend/divisor pair through a valid/ready handshake, produces one quotient bit per cycle, and returns quotient and remainder with RISC-V DIV/DIVU/REM/REMU semantics, including the divide-by-zero and signed-overflow results.

## Interface
- WIDTH, 64, operand, quotient and remainder width in bits (≥ 4)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  divider idle and able to accept
- in_signed  in  1  1 = signed (DIV/REM), 0 = unsigned
- dividend  in  WIDTH  numerator
- divisor  in  WIDTH  denominator
- flush  in  1  abandon current operation; synchronous
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- quotient  out  WIDTH  result quotient
- remainder  out  WIDTH  result remainder

## Operation
- States: IDLE, BUSY, FIXUP, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch operands, in_signed, sign_q=sa^sb, sign_r=sa, and take magnitudes (signed mode only). Clear the partial remainder, load the iteration counter with WIDTH-1, then go to BUSY.
- BUSY: each cycle, shift {rem,quo} left 1 and try rem−|divisor|. If the result is non-negative, keep it and set the quotient LSB to 1. Otherwise restore and set the quotient LSB to 0. When the counter reaches 0, go to FIXUP. Otherwise decrement.
- FIXUP: negate the quotient if sign_q, and the remainder if sign_r (signed mode only). Then apply overrides:
  - divisor==0: quotient = all ones, remainder = dividend.
  - signed, dividend = 1<<(WIDTH−1), divisor = all ones: quotient = dividend, remainder = 0.
  - Go to DONE.
- DONE: out_valid=1. quotient and remainder stay stable until out_ready. On out_valid&&out_ready, go to IDLE.
- in_ready is 1 only in IDLE. There is no accept in the same cycle as a result handoff: in_ready rises the cycle after the handoff.
- flush=1 in any state: go to IDLE next edge, drop any result, out_valid=0 next cycle. flush has priority over in_valid and out_ready in the same cycle.
- Widths: internal partial remainder is WIDTH+1 bits. Magnitude of the most-negative value is taken as unsigned WIDTH bits, with no overflow.

## Timing
- Reset: state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, counter=0. Reset applies immediately, including mid-operation.
- Latency: accept at edge N, out_valid high from edge N+WIDTH+2 (1 latch + WIDTH steps + 1 fixup), i.e. 66 cycles for WIDTH=64.
- Throughput: one operation per WIDTH+3 cycles when out_ready is held high.
- Outputs are registered. No combinational path from in_valid or out_ready to any output except none; in_ready and out_valid are decoded from state only.

## Configuration
- DIVIDER_EARLY_TERM_EN defined:
  - Divide-by-zero and signed-overflow operands are detected at accept. They skip BUSY/FIXUP, load the override results, and go straight to DONE, so out_valid rises at N+1.
  - Unsigned dividend < divisor also goes straight to DONE with quotient=0, remainder=dividend.
- Undefined: every operation takes the full WIDTH+2 latency. Results are identical in both builds.

## Structure
- Package div_pkg holds:
  - The state enum (IDLE/BUSY/FIXUP/DONE).
  - Counter width localparam CNT_W = $clog2(WIDTH).
  - Helper functions for two's-complement magnitude and conditional negate.
- One sub-module, div_step: combinational single restoring step. Inputs are {rem,quo} and divisor magnitude; outputs are the next {rem,quo}. It is instantiated once inside iter_divider.

## Test plan
- Unsigned 100 / 7, out_ready=1 -> quotient=14, remainder=2, out_valid exactly 66 cycles after accept (no EARLY_TERM).
- Signed −7 / 2 -> quotient=−3 (0xFFFF_FFFF_FFFF_FFFD), remainder=−1. Signed 7 / −2 -> quotient=−3, remainder=1.
- 5 / 0, signed and unsigned -> quotient=0xFFFF_FFFF_FFFF_FFFF, remainder=5. With EARLY_TERM, out_valid at accept+1.
- Signed 0x8000_0000_0000_0000 / −1 -> quotient=0x8000_0000_0000_0000, remainder=0.
- Backpressure: out_ready low for 5 cycles in DONE -> outputs stable, in_ready=0. Handoff on the 6th cycle, in_ready=1 the next cycle.
- Mid-operation events, each -> state IDLE, out_valid=0, in_ready=1, with the next operation (9/3 -> q=3, r=0) correct:
  - flush at BUSY cycle 10.
  - rst asserted at BUSY cycle 20 (outputs zeroed immediately).
